mesm6_mem_arbiter: RTL

// - Sits between mesm6_core and the single-ported main memory. Merges the core's instruction
//   bus (ibus_*) and data bus (dbus_*) onto one memory port, one access at a time.
// - Buffers read data and delivers each completion as a level-held done until the core takes it.
// - When fetch and data access are requested together, it presents both dones in the same cycle,

---
 rtl/mesm6_mem_arbiter_pkg.sv | 11 +
 rtl/mesm6_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mesm6_mem_arbiter_pkg.sv
// Shared definitions for the mesm6 memory arbiter: FSM state encoding.
package mesm6_mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_DATA  = 2'd1;
  localparam logic [1:0] ARB_FETCH = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

endpackage

// File: rtl/mesm6_mem_arbiter.sv
// Merges the mesm6 core instruction and data buses onto one single-ported memory,
// serving one access at a time and presenting both completions together.
module mesm6_mem_arbiter
  import mesm6_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 48,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_hold,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state;
  logic              fetch_pend;
  logic              data_pend;
  logic              fetch_served;
  logic              data_served;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              dreq;

  assign dreq = dbus_read | dbus_write;

  // Both accesses are latched up front so the second one of a pair is immune to bus changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      fetch_pend   <= 1'b0;
      data_pend    <= 1'b0;
      fetch_served <= 1'b0;
      data_served  <= 1'b0;
      data_we      <= 1'b0;
      data_addr    <= '0;
      fetch_addr   <= '0;
      data_wdata   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ibus_input   <= '0;
      dbus_input   <= '0;
      ibus_done    <= 1'b0;
      dbus_done    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (dreq || ibus_fetch) begin
            data_pend    <= dreq;
            fetch_pend   <= ibus_fetch;
            data_served  <= 1'b0;
            fetch_served <= 1'b0;
            data_we      <= dbus_write;
            data_addr    <= dbus_addr;
            data_wdata   <= dbus_output;
            fetch_addr   <= ibus_addr;
            mem_req      <= 1'b1;
            if (dreq && (DATA_FIRST || !ibus_fetch)) begin
              state     <= ARB_DATA;
              mem_we    <= dbus_write;
              mem_addr  <= dbus_addr;
              mem_wdata <= dbus_output;
            end else begin
              state    <= ARB_FETCH;
              mem_we   <= 1'b0;
              mem_addr <= ibus_addr;
            end
          end
        end

        ARB_DATA: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= data_we;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
          end else if (mem_ready) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            data_pend   <= 1'b0;
            data_served <= 1'b1;
            if (!data_we) begin
              dbus_input <= mem_rdata;
            end
            if (fetch_pend) begin
              state <= ARB_FETCH;
            end else begin
              state     <= ARB_DONE;
              ibus_done <= fetch_served;
              dbus_done <= 1'b1;
            end
          end
        end

        ARB_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fetch_addr;
          end else if (mem_ready) begin
            mem_req      <= 1'b0;
            fetch_pend   <= 1'b0;
            fetch_served <= 1'b1;
            ibus_input   <= mem_rdata;
            if (data_pend) begin
              state <= ARB_DATA;
            end else begin
              state     <= ARB_DONE;
              ibus_done <= 1'b1;
              dbus_done <= data_served;
            end
          end
        end

        ARB_DONE: begin
          if (!core_hold) begin
            state     <= ARB_IDLE;
            ibus_done <= 1'b0;
            dbus_done <= 1'b0;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
